debug_control_mc: RTL and testbench
===================================

Name: debug_control_mc

Overview:
Parametrised multi-channel successor to the single-pair debug controller, on the CPU side of the JTAGlet TAP.
- Takes TAP opcode/data and an asynchronous ready strobe, synchronises it, and executes halt/resume/reset and memory accesses.
- Drives NUM_CH independent memory ports, each with its own address/data register, completion handshake, timeout and optional address auto-increment.
- Returns read data and a sticky status word to the TAP.

Parameters:
DATA_W, 64, width of TAP user data and of every memory data bus
ADDR_W, 64, width of each channel address (ADDR_W <= DATA_W)
NUM_CH, 2, number of memory channels (1..16)
TIMEOUT, 255, cycles to wait for read ready before abort (>=1)
RST_STRETCH, 1023, cycles cpu_resetn_cpu held low after a reset op

Ports:
cpu_clk  in  1  system clock
sys_rstn  in  1  asynchronous active-low reset
jtag_userOp_ready  in  1  async strobe from TAP; a rising edge means an op is valid
jtag_userOp  in  8  opcode, stable while ready is high
jtag_userData  in  DATA_W  operand, stable while ready is high
cpu_userData  out  DATA_W  readback to TAP
mem_addr  out  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
mem_wdata  out  NUM_CH*DATA_W  per-channel write data
mem_rdata  in  NUM_CH*DATA_W  per-channel read data
mem_rdata_ready  in  NUM_CH  per-channel read-complete pulse
mem_ce  out  NUM_CH  per-channel one-cycle access strobe
mem_we  out  NUM_CH  per-channel write qualifier, only with mem_ce
cpu_halt_cpu  out  1  halt request
cpu_resetn_cpu  out  1  stretched active-low CPU reset
busy  out  1  a memory access is in progress

Behaviour:
- Reset values: all regs 0; cpu_userData=0, mem_ce/we=0, cpu_halt_cpu=0, cpu_resetn_cpu=1, busy=0, CHSEL=0, status=0, FSM=IDLE.
- Sync: jtag_userOp_ready passes through a 2-flop synchroniser, then rising-edge detect gives a one-cycle exec. Op/data are sampled on exec. Latency from ready edge to exec is 3 cycles.
- Control ops, accepted even while busy:
  - 0x01 sets halt.
  - 0x02 clears halt.
  - 0x03 clears halt and loads the stretch counter to RST_STRETCH. cpu_resetn_cpu = (counter==0). The counter decrements to 0.
  - 0x00 does nothing.
- Register ops, rejected while busy (set OVR):
  - 0x80 ADDR[CHSEL] <= userData[ADDR_W-1:0].
  - 0x81 WDATA[CHSEL] <= userData.
  - 0x82 CHSEL <= userData[3:0]. If the value is >= NUM_CH, CHSEL is unchanged and BADOP is set.
  - 0x83 cpu_userData <= zero-extended status.
  - 0x84 clears TMO, BADOP, OVR.
- Memory ops, rejected while busy (set OVR):
  - 0x04 read, 0x05 write.
  - 0x06/0x07 are the same plus auto-increment.
  - The channel is latched as CHSEL at exec.
- Any other opcode: set BADOP, no other effect.
- FSM:
  - IDLE -> STROBE on a memory op.
  - STROBE: one cycle with mem_ce[ch]=1, mem_we[ch]=write. Write -> DONE. Read -> WAIT with timer=0.
  - WAIT: on mem_rdata_ready[ch], cpu_userData <= rdata[ch] -> DONE. Ready on other channels is ignored. If the timer reaches TIMEOUT first, set TMO, leave cpu_userData unchanged, and go to IDLE with no increment.
  - DONE: if auto-increment, ADDR[ch] += DATA_W/8, wrapping mod 2^ADDR_W. Then -> IDLE.
- busy=1 in STROBE/WAIT/DONE.
- Ready arriving in the same cycle as STROBE is not accepted; it is only sampled in WAIT.
- Status word:
  - bit0 busy, bit1 TMO, bit2 halt, bit3 ~cpu_resetn_cpu, bit4 BADOP, bit5 OVR.
  - [11:8] CHSEL, [19:16] last-completed channel.
  - TMO, BADOP and OVR are sticky.
- Reset op mid-access does not abort the access. sys_rstn asserted mid-access returns everything to reset values immediately.
- Only one mem_ce bit is ever high.

Test Plan:
- Reset release -> all outputs at reset values, cpu_resetn_cpu=1. Op 0x01 -> halt=1 three cycles after the ready edge. Op 0x03 -> halt=0, resetn low for 1023 cycles.
- CHSEL=1, ADDR=0x1000, WDATA=0xDEADBEEF, op 0x07 -> mem_ce[1]=mem_we[1]=1 for one cycle, port 1 addr=0x1000 and wdata=0xDEADBEEF during the strobe, ADDR[1] becomes 0x1008, channel 0 untouched.
- CHSEL=0, op 0x04, rdata[0]=0x55 with ready 5 cycles later -> cpu_userData=0x55, busy falls. A ready pulse on channel 1 during WAIT is ignored.
- Read with no ready -> after 255 cycles TMO=1, ADDR unchanged. Op 0x83 -> cpu_userData bit1=1. Op 0x84 then 0x83 -> bit1=0.
- ADDR=0xFFFFFFFFFFFFFFF8, op 0x06 completes -> ADDR wraps to 0x0.
- Op 0x82 with data 5 (NUM_CH=2) -> BADOP=1, CHSEL unchanged. Op 0x81 issued while busy -> OVR=1, WDATA unchanged.

Source files
------------

// File: rtl/debug_control_mc.sv
// Multi-channel debug controller on the CPU side of the JTAGlet TAP.
// It executes TAP ops (halt/resume/reset, register ops, memory accesses) across NUM_CH memory ports.
module debug_control_mc #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int NUM_CH      = 2,
  parameter int TIMEOUT     = 255,
  parameter int RST_STRETCH = 1023
) (
  input  logic                     cpu_clk,
  input  logic                     sys_rstn,
  input  logic                     jtag_userOp_ready,
  input  logic [7:0]               jtag_userOp,
  input  logic [DATA_W-1:0]        jtag_userData,
  output logic [DATA_W-1:0]        cpu_userData,
  output logic [NUM_CH*ADDR_W-1:0] mem_addr,
  output logic [NUM_CH*DATA_W-1:0] mem_wdata,
  input  logic [NUM_CH*DATA_W-1:0] mem_rdata,
  input  logic [NUM_CH-1:0]        mem_rdata_ready,
  output logic [NUM_CH-1:0]        mem_ce,
  output logic [NUM_CH-1:0]        mem_we,
  output logic                     cpu_halt_cpu,
  output logic                     cpu_resetn_cpu,
  output logic                     busy
);

  localparam int CNT_W = $clog2(RST_STRETCH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_sync1, r_sync2, r_syncPrev;
  logic               w_exec, w_busy, w_isCtrlOp, w_isMemOp, w_isRegOp;
  logic               w_chReady, w_timeout;
  logic [DATA_W-1:0]  w_chRdata, w_status, r_userData;
  logic [ADDR_W-1:0]  r_addr  [NUM_CH];
  logic [DATA_W-1:0]  r_wdata [NUM_CH];
  logic [3:0]         r_chsel, r_ch, r_lastCh;
  logic               r_isWrite, r_autoInc;
  logic               r_halt, r_tmo, r_badop, r_ovr;
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_rstCnt;

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_syncPrev <= 1'b0;
    end else begin
      r_sync1    <= jtag_userOp_ready;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  assign w_exec     = r_sync2 & ~r_syncPrev;
  assign w_busy     = (r_state != S_IDLE);
  assign w_isCtrlOp = (jtag_userOp[7:2] == 6'b000000);
  assign w_isMemOp  = (jtag_userOp[7:2] == 6'b000001);
  assign w_isRegOp  = (jtag_userOp >= 8'h80) && (jtag_userOp <= 8'h84);
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_status   = DATA_W'({r_lastCh, 4'b0000, r_chsel, 2'b00, r_ovr, r_badop,
                               ~cpu_resetn_cpu, r_halt, r_tmo, w_busy});

  // Only the latched channel's ready/rdata matter; other channels are ignored.
  always_comb begin
    w_chReady = 1'b0;
    w_chRdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == 4'(i)) begin
        w_chReady = mem_rdata_ready[i];
        w_chRdata = mem_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_exec && w_isMemOp) w_next = S_STROBE;
      S_STROBE: w_next = r_isWrite ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (w_chReady)      w_next = S_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ce = '0;
    mem_we = '0;
    busy   = w_busy;
    if (r_state == S_STROBE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_ch == 4'(i)) begin
          mem_ce[i] = 1'b1;
          mem_we[i] = r_isWrite;
        end
      end
    end
  end

  // Op decode and access bookkeeping; FSM and register ops never write the same reg in one cycle.
  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_userData <= '0;
      r_chsel    <= '0;
      r_ch       <= '0;
      r_lastCh   <= '0;
      r_isWrite  <= 1'b0;
      r_autoInc  <= 1'b0;
      r_halt     <= 1'b0;
      r_tmo      <= 1'b0;
      r_badop    <= 1'b0;
      r_ovr      <= 1'b0;
      r_timer    <= '0;
    end else begin
      case (r_state)
        S_STROBE: r_timer <= '0;
        S_WAIT: begin
          if (w_chReady)      r_userData <= w_chRdata;
          else if (w_timeout) r_tmo <= 1'b1;
          else                r_timer <= r_timer + TMR_W'(1);
        end
        S_DONE:   r_lastCh <= r_ch;
        default: ;
      endcase
      if (w_exec) begin
        if (w_isCtrlOp) begin
          case (jtag_userOp[1:0])
            2'd1:    r_halt <= 1'b1;
            2'd2:    r_halt <= 1'b0;
            2'd3:    r_halt <= 1'b0;
            default: ;
          endcase
        end else if (w_isMemOp || w_isRegOp) begin
          if (w_busy) begin
            r_ovr <= 1'b1;
          end else if (w_isMemOp) begin
            r_ch      <= r_chsel;
            r_isWrite <= jtag_userOp[0];
            r_autoInc <= jtag_userOp[1];
          end else begin
            case (jtag_userOp)
              8'h82: begin
                if ({1'b0, jtag_userData[3:0]} < 5'(NUM_CH)) r_chsel <= jtag_userData[3:0];
                else                                         r_badop <= 1'b1;
              end
              8'h83: r_userData <= w_status;
              8'h84: begin
                r_tmo   <= 1'b0;
                r_badop <= 1'b0;
                r_ovr   <= 1'b0;
              end
              default: ;
            endcase
          end
        end else begin
          r_badop <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn)                                          r_rstCnt <= '0;
    else if (w_exec && w_isCtrlOp && jtag_userOp[1:0] == 2'd3) r_rstCnt <= CNT_W'(RST_STRETCH);
    else if (r_rstCnt != '0)                                r_rstCnt <= r_rstCnt - CNT_W'(1);
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_exec && !w_busy && jtag_userOp == 8'h80 && r_chsel == 4'(i))
          r_addr[i] <= jtag_userData[ADDR_W-1:0];
        if (r_state == S_DONE && r_autoInc && r_ch == 4'(i))
          r_addr[i] <= r_addr[i] + ADDR_W'(DATA_W / 8);
        if (w_exec && !w_busy && jtag_userOp == 8'h81 && r_chsel == 4'(i))
          r_wdata[i] <= jtag_userData;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign mem_addr[g*ADDR_W +: ADDR_W]  = r_addr[g];
    assign mem_wdata[g*DATA_W +: DATA_W] = r_wdata[g];
  end

  assign cpu_userData   = r_userData;
  assign cpu_halt_cpu   = r_halt;
  assign cpu_resetn_cpu = (r_rstCnt == '0);

endmodule

// File: tb/tb_debug_control_mc.sv
// Directed bench for debug_control_mc: strobes are checked against a scoreboard queue,
// everything else against constants derived from the op sequence.
module tb_debug_control_mc;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int NUM_CH = 2;

  logic                     cpu_clk, sys_rstn;
  logic                     jtag_userOp_ready;
  logic [7:0]               jtag_userOp;
  logic [DATA_W-1:0]        jtag_userData, cpu_userData;
  logic [NUM_CH*ADDR_W-1:0] mem_addr;
  logic [NUM_CH*DATA_W-1:0] mem_wdata, mem_rdata;
  logic [NUM_CH-1:0]        mem_rdata_ready, mem_ce, mem_we;
  logic                     cpu_halt_cpu, cpu_resetn_cpu, busy;

  typedef struct {
    int          ch;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } strobe_t;

  strobe_t sbQ[$];
  int      checks = 0;
  int      errors = 0;
  int      n;

  debug_control_mc dut (
    .cpu_clk          (cpu_clk),
    .sys_rstn         (sys_rstn),
    .jtag_userOp_ready(jtag_userOp_ready),
    .jtag_userOp      (jtag_userOp),
    .jtag_userData    (jtag_userData),
    .cpu_userData     (cpu_userData),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_rdata_ready  (mem_rdata_ready),
    .mem_ce           (mem_ce),
    .mem_we           (mem_we),
    .cpu_halt_cpu     (cpu_halt_cpu),
    .cpu_resetn_cpu   (cpu_resetn_cpu),
    .busy             (busy)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic raiseReady(input logic [7:0] op, input logic [63:0] data);
    jtag_userOp_ready = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    jtag_userOp       = op;
    jtag_userData     = data;
    jtag_userOp_ready = 1'b1;
  endtask

  // Returns just after the edge at which the op takes effect.
  task automatic applyStimulus(input logic [7:0] op, input logic [63:0] data);
    raiseReady(op, data);
    repeat (3) @(posedge cpu_clk);
    #1;
    jtag_userOp_ready = 1'b0;
  endtask

  task automatic pushStrobe(input int ch, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    strobe_t s;
    s.ch = ch; s.we = we; s.addr = addr; s.wdata = wdata;
    sbQ.push_back(s);
  endtask

  task automatic stepClk(input int cycles);
    repeat (cycles) @(posedge cpu_clk);
    #1;
  endtask

  task automatic waitIdle(input int limit, output int cycles);
    cycles = 0;
    while (busy && cycles < limit) begin
      @(posedge cpu_clk);
      #1;
      cycles++;
    end
  endtask

  // Strobe monitor: every mem_ce cycle must match the next queued expectation.
  always @(negedge cpu_clk) begin
    if (sys_rstn && mem_ce != '0) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected strobe", 64'(mem_ce), 64'd0);
      end else begin
        strobe_t e;
        e = sbQ.pop_front();
        checkOutput("strobe ce", 64'(mem_ce), 64'(1) << e.ch);
        checkOutput("strobe we", 64'(mem_we), 64'(e.we) << e.ch);
        checkOutput("strobe addr", mem_addr[e.ch*ADDR_W +: ADDR_W], e.addr);
        checkOutput("strobe wdata", mem_wdata[e.ch*DATA_W +: DATA_W], e.wdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rstn          = 1'b0;
    jtag_userOp_ready = 1'b0;
    jtag_userOp       = 8'h00;
    jtag_userData     = '0;
    mem_rdata         = '0;
    mem_rdata_ready   = '0;
    stepClk(3);
    sys_rstn = 1'b1;
    stepClk(1);

    checkOutput("reset userData", cpu_userData, 64'd0);
    checkOutput("reset ce/we", 64'({mem_ce, mem_we}), 64'd0);
    checkOutput("reset halt/resetn/busy", 64'({cpu_halt_cpu, cpu_resetn_cpu, busy}), 64'b010);
    checkOutput("reset addr1", mem_addr[ADDR_W +: ADDR_W], 64'd0);

    // Halt latency: nothing after two edges, halt after the third.
    raiseReady(8'h01, 64'd0);
    stepClk(2);
    checkOutput("halt not early", 64'(cpu_halt_cpu), 64'd0);
    stepClk(1);
    checkOutput("halt set", 64'(cpu_halt_cpu), 64'd1);
    jtag_userOp_ready = 1'b0;

    applyStimulus(8'h02, 64'd0);
    checkOutput("halt cleared", 64'(cpu_halt_cpu), 64'd0);

    applyStimulus(8'h01, 64'd0);
    applyStimulus(8'h03, 64'd0);
    checkOutput("reset op clears halt", 64'(cpu_halt_cpu), 64'd0);
    checkOutput("resetn low", 64'(cpu_resetn_cpu), 64'd0);
    n = 0;
    while (!cpu_resetn_cpu && n < 2000) begin
      stepClk(1);
      n++;
    end
    checkOutput("resetn stretch cycles", 64'(n), 64'd1023);

    // Write with auto-increment on channel 1.
    applyStimulus(8'h82, 64'd1);
    applyStimulus(8'h80, 64'h1000);
    applyStimulus(8'h81, 64'hDEADBEEF);
    pushStrobe(1, 1'b1, 64'h1000, 64'hDEADBEEF);
    applyStimulus(8'h07, 64'd0);
    waitIdle(20, n);
    checkOutput("write busy falls", 64'(busy), 64'd0);
    checkOutput("ch1 addr incremented", mem_addr[ADDR_W +: ADDR_W], 64'h1008);
    checkOutput("ch0 addr untouched", mem_addr[0 +: ADDR_W], 64'd0);
    checkOutput("ch0 wdata untouched", mem_wdata[0 +: DATA_W], 64'd0);

    // Read on channel 0: ready in the strobe cycle and ready on channel 1 are both ignored.
    applyStimulus(8'h82, 64'd0);
    pushStrobe(0, 1'b0, 64'd0, 64'd0);
    applyStimulus(8'h04, 64'd0);
    mem_rdata[0 +: DATA_W] = 64'h33;
    mem_rdata_ready[0]     = 1'b1;
    stepClk(1);
    mem_rdata_ready[0]     = 1'b0;
    checkOutput("strobe-cycle ready ignored", cpu_userData, 64'd0);
    mem_rdata[DATA_W +: DATA_W] = 64'hAA;
    mem_rdata_ready[1]          = 1'b1;
    stepClk(1);
    mem_rdata_ready[1]          = 1'b0;
    stepClk(3);
    checkOutput("other channel ready ignored", 64'(busy), 64'd1);
    mem_rdata[0 +: DATA_W] = 64'h55;
    mem_rdata_ready[0]     = 1'b1;
    stepClk(1);
    mem_rdata_ready[0]     = 1'b0;
    waitIdle(20, n);
    checkOutput("read busy falls", 64'(busy), 64'd0);
    checkOutput("read data", cpu_userData, 64'h55);

    // Timeout read with auto-increment; a WDATA op lands while busy.
    applyStimulus(8'h80, 64'h2000);
    pushStrobe(0, 1'b0, 64'h2000, 64'd0);
    applyStimulus(8'h06, 64'd0);
    applyStimulus(8'h81, 64'h1234);
    waitIdle(400, n);
    checkOutput("timeout busy falls", 64'(busy), 64'd0);
    checkOutput("timeout not early", 64'(n > 200), 64'd1);
    checkOutput("timeout addr unchanged", mem_addr[0 +: ADDR_W], 64'h2000);
    checkOutput("rejected wdata", mem_wdata[0 +: DATA_W], 64'd0);
    checkOutput("timeout userData kept", cpu_userData, 64'h55);
    applyStimulus(8'h83, 64'd0);
    checkOutput("status tmo+ovr", cpu_userData, 64'h22);
    applyStimulus(8'h84, 64'd0);
    applyStimulus(8'h83, 64'd0);
    checkOutput("status cleared", cpu_userData, 64'h00);

    // Address wrap on auto-increment.
    applyStimulus(8'h80, 64'hFFFFFFFFFFFFFFF8);
    pushStrobe(0, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0);
    applyStimulus(8'h06, 64'd0);
    stepClk(2);
    mem_rdata[0 +: DATA_W] = 64'h77;
    mem_rdata_ready[0]     = 1'b1;
    stepClk(1);
    mem_rdata_ready[0]     = 1'b0;
    waitIdle(20, n);
    checkOutput("wrap busy falls", 64'(busy), 64'd0);
    checkOutput("addr wrapped", mem_addr[0 +: ADDR_W], 64'd0);
    checkOutput("wrap read data", cpu_userData, 64'h77);

    // Bad channel select and unknown opcode.
    applyStimulus(8'h82, 64'd1);
    applyStimulus(8'h82, 64'd5);
    applyStimulus(8'h83, 64'd0);
    checkOutput("status badop chsel kept", cpu_userData, 64'h110);
    applyStimulus(8'h84, 64'd0);
    applyStimulus(8'h55, 64'd0);
    applyStimulus(8'h83, 64'd0);
    checkOutput("status unknown op", cpu_userData, 64'h110);

    stepClk(2);
    checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
